// File: rtl/adder_pipe_pkg.sv
// Shared constants and result type for the pipelined adder and its result collector.
package adder_pipe_pkg;

    localparam int unsigned SUM_W         = 33;
    localparam int unsigned ADDER_LATENCY = 2;
    localparam int unsigned TAG_W         = 4;
    localparam int unsigned RESULT_DEPTH  = 4;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [SUM_W-1:0] sum;
    } adder_result_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with any DEPTH >= 2; head is zero when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so push is allowed even when full.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/adder_result_collector.sv
// Turns the fixed-latency adder output into a ready/valid stream with credit-based issue.
// Optional carry-pop statistics counter enabled by defining COLLECTOR_STATS_EN.
module adder_result_collector
    import adder_pipe_pkg::*;
#(
    parameter int unsigned SUM_W   = adder_pipe_pkg::SUM_W,
    parameter int unsigned LATENCY = ADDER_LATENCY,
    parameter int unsigned DEPTH   = RESULT_DEPTH,
    parameter int unsigned TAG_W   = adder_pipe_pkg::TAG_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       issue_valid,
    input  logic [TAG_W-1:0]           issue_tag,
    output logic                       issue_ready,
    input  logic [SUM_W-1:0]           sum_in,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [SUM_W-1:0]           res_sum,
    output logic [TAG_W-1:0]           res_tag,
    output logic                       res_carry,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef COLLECTOR_STATS_EN
    ,
    output logic [15:0]                stat_carry_cnt
`endif
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = TAG_W + SUM_W;
    localparam logic [OCC_W-1:0] MAX_OCC = OCC_W'(DEPTH);

    logic [LATENCY-1:0] r_dl_vld;
    logic [TAG_W-1:0]   r_dl_tag [LATENCY];
    logic [OCC_W-1:0]   r_occ;
    logic [OCC_W-1:0]   w_occ_d;
    logic               w_accept;
    logic               w_pop;
    logic               w_push;
    logic [ENT_W-1:0]   w_push_data;
    logic [ENT_W-1:0]   w_head;
    logic               w_fifo_full;
    logic               w_fifo_empty;

    // Credits come from registered occupancy only; reset masks issue during the reset cycle.
    assign issue_ready = !reset && (r_occ < MAX_OCC);
    assign w_accept    = issue_valid && issue_ready;
    assign res_valid   = !w_fifo_empty;
    assign w_pop       = res_valid && res_ready;
    assign w_push      = r_dl_vld[LATENCY-1];
    assign w_push_data = {r_dl_tag[LATENCY-1], sum_in};
    assign res_tag     = w_head[ENT_W-1:SUM_W];
    assign res_sum     = w_head[SUM_W-1:0];
    assign res_carry   = res_sum[SUM_W-1];
    assign occupancy   = r_occ;

    always_comb begin
        w_occ_d = r_occ;
        if (w_accept && !w_pop) begin
            w_occ_d = r_occ + OCC_W'(1);
        end else if (w_pop && !w_accept) begin
            w_occ_d = r_occ - OCC_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dl_vld <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                r_dl_tag[k] <= '0;
            end
            r_occ <= '0;
        end else begin
            r_dl_vld[0] <= w_accept;
            r_dl_tag[0] <= issue_tag;
            for (int k = 1; k < LATENCY; k++) begin
                r_dl_vld[k] <= r_dl_vld[k-1];
                r_dl_tag[k] <= r_dl_tag[k-1];
            end
            r_occ <= w_occ_d;
        end
    end

    // Every in-flight issue holds a credit, so a push can never meet a full FIFO without a pop.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(w_push && w_fifo_full && !w_pop));
        end
    end

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_head)
    );

`ifdef COLLECTOR_STATS_EN
    logic [15:0] r_carry_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_carry_cnt <= '0;
        end else if (w_pop && res_carry && (r_carry_cnt != 16'hFFFF)) begin
            r_carry_cnt <= r_carry_cnt + 16'd1;
        end
    end

    assign stat_carry_cnt = r_carry_cnt;
`endif

endmodule

// File: tb/tb_adder_result_collector.sv
// Directed bench for adder_result_collector with a two-stage adder model feeding sum_in.
module tb_adder_result_collector;
    import adder_pipe_pkg::*;

    logic        clock;
    logic        reset;
    logic        issue_valid;
    logic [3:0]  issue_tag;
    logic        issue_ready;
    logic [32:0] sum_in;
    logic        res_valid;
    logic        res_ready;
    logic [32:0] res_sum;
    logic [3:0]  res_tag;
    logic        res_carry;
    logic [2:0]  occupancy;
`ifdef COLLECTOR_STATS_EN
    logic [15:0] stat_carry_cnt;
`endif

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [32:0] add_s1;
    logic [32:0] add_s2;

    int n_cmp = 0;
    int n_err = 0;

    adder_result_collector dut (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_tag   (issue_tag),
        .issue_ready (issue_ready),
        .sum_in      (sum_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sum     (res_sum),
        .res_tag     (res_tag),
        .res_carry   (res_carry),
        .occupancy   (occupancy)
`ifdef COLLECTOR_STATS_EN
        ,
        .stat_carry_cnt (stat_carry_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Two-stage adder: operands presented in cycle N give sum_in in cycle N+2.
    always @(posedge clock) begin
        add_s1 <= {1'b0, op_a} + {1'b0, op_b};
        add_s2 <= add_s1;
    end
    assign sum_in = add_s2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] t, input logic [31:0] a,
                         input logic [31:0] b, input logic rr);
        issue_valid = v;
        issue_tag   = t;
        op_a        = a;
        op_b        = b;
        res_ready   = rr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        #1;
        check("rst_ready_during_reset", 64'(issue_ready), 64'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_ready_after", 64'(issue_ready), 64'd1);
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_sum", 64'(res_sum), 64'd0);
        check("rst_tag", 64'(res_tag), 64'd0);
        check("rst_carry", 64'(res_carry), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);

        // Single carry-producing issue, latency 3 to res_valid.
        drive(1'b1, 4'd3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        #1;
        check("t1_ready_c0", 64'(issue_ready), 64'd1);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        #1;
        check("t1_valid_c1", 64'(res_valid), 64'd0);
        check("t1_occ_c1", 64'(occupancy), 64'd1);
        step();
        #1;
        check("t1_valid_c2", 64'(res_valid), 64'd0);
        step();
        #1;
        check("t1_valid_c3", 64'(res_valid), 64'd1);
        check("t1_sum_c3", 64'(res_sum), 64'h1_0000_0000);
        check("t1_carry_c3", 64'(res_carry), 64'd1);
        check("t1_tag_c3", 64'(res_tag), 64'd3);
        check("t1_occ_c3", 64'(occupancy), 64'd1);
        step();
        #1;
        check("t1_valid_c4", 64'(res_valid), 64'd0);
        check("t1_occ_c4", 64'(occupancy), 64'd0);

        // Consumer stalled: only DEPTH issues accepted.
        for (int i = 0; i < 6; i++) begin
            step();
            drive(1'b1, 4'(i), 32'(i), 32'h100, 1'b0);
            #1;
            check("t2_ready", 64'(issue_ready), 64'(i < 4));
            check("t2_occ", 64'(occupancy), (i < 4) ? 64'(i) : 64'd4);
        end
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        #1;
        check("t2_ready_full", 64'(issue_ready), 64'd0);
        check("t2_occ_full", 64'(occupancy), 64'd4);
        check("t2_valid0", 64'(res_valid), 64'd1);
        check("t2_tag0", 64'(res_tag), 64'd0);
        check("t2_sum0", 64'(res_sum), 64'h100);
        for (int j = 1; j < 4; j++) begin
            step();
            #1;
            check("t2_ready_reopen", 64'(issue_ready), 64'd1);
            check("t2_valid", 64'(res_valid), 64'd1);
            check("t2_tag", 64'(res_tag), 64'(j));
            check("t2_sum", 64'(res_sum), 64'h100 + 64'(j));
            check("t2_occ_drain", 64'(occupancy), 64'(4 - j));
        end
        step();
        #1;
        check("t2_valid_empty", 64'(res_valid), 64'd0);
        check("t2_occ_empty", 64'(occupancy), 64'd0);

        // Back-to-back issue with consumer always ready.
        for (int i = 0; i < 11; i++) begin
            step();
            drive(i < 8, 4'(i), 32'h1 << (4 * i), 32'h2 << (4 * i), 1'b1);
            #1;
            if (i < 8) check("t3_ready", 64'(issue_ready), 64'd1);
            if (i >= 3) begin
                check("t3_valid", 64'(res_valid), 64'd1);
                check("t3_tag", 64'(res_tag), 64'(i - 3));
                check("t3_sum", 64'(res_sum), 64'h3 << (4 * (i - 3)));
            end
            if (i >= 3 && i <= 8) check("t3_occ", 64'(occupancy), 64'd3);
        end
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        #1;
        check("t3_valid_end", 64'(res_valid), 64'd0);
        check("t3_occ_end", 64'(occupancy), 64'd0);

        // Fill, then pop and issue every cycle across several pointer wraps.
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1'b1, 4'(i), 32'h200 + 32'(i), 32'd0, 1'b0);
            #1;
            check("t4_fill_ready", 64'(issue_ready), 64'd1);
        end
        step();
        drive(1'b1, 4'd4, 32'h204, 32'd0, 1'b1);
        #1;
        check("t4_full_ready", 64'(issue_ready), 64'd0);
        check("t4_full_occ", 64'(occupancy), 64'd4);
        check("t4_tag0", 64'(res_tag), 64'd0);
        check("t4_sum0", 64'(res_sum), 64'h200);
        for (int i = 5; i < 20; i++) begin
            step();
            drive(i <= 16, 4'(i - 1), 32'h200 + 32'(i - 1), 32'd0, 1'b1);
            #1;
            check("t4_valid", 64'(res_valid), 64'd1);
            check("t4_tag", 64'(res_tag), 64'(i - 4));
            check("t4_sum", 64'(res_sum), 64'h200 + 64'(i - 4));
            if (i <= 16) check("t4_ready", 64'(issue_ready), 64'd1);
            if (i <= 17) check("t4_occ", 64'(occupancy), 64'd3);
        end
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        #1;
        check("t4_valid_end", 64'(res_valid), 64'd0);
        check("t4_occ_end", 64'(occupancy), 64'd0);

        // Reset with two results stored and two in flight.
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1'b1, 4'(i + 1), 32'h300 + 32'(i + 1), 32'd0, 1'b0);
        end
        step();
        reset = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        #1;
        check("t5_ready_in_reset", 64'(issue_ready), 64'd0);
        step();
        reset = 1'b0;
        drive(1'b1, 4'd9, 32'h1234_5678, 32'h1111_1111, 1'b1);
        #1;
        check("t5_valid_post", 64'(res_valid), 64'd0);
        check("t5_occ_post", 64'(occupancy), 64'd0);
        check("t5_ready_post", 64'(issue_ready), 64'd1);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        #1;
        check("t5_no_stale_c1", 64'(res_valid), 64'd0);
        step();
        #1;
        check("t5_no_stale_c2", 64'(res_valid), 64'd0);
        step();
        #1;
        check("t5_valid_c3", 64'(res_valid), 64'd1);
        check("t5_tag_c3", 64'(res_tag), 64'd9);
        check("t5_sum_c3", 64'(res_sum), 64'h0_2345_6789);
        check("t5_carry_c3", 64'(res_carry), 64'd0);
        step();
        #1;
        check("t5_valid_c4", 64'(res_valid), 64'd0);
        check("t5_occ_c4", 64'(occupancy), 64'd0);

`ifdef COLLECTOR_STATS_EN
        check("st_after_reset", 64'(stat_carry_cnt), 64'd0);
        begin
            logic [31:0] sa [5];
            logic [31:0] sb [5];
            sa = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
            sb = '{32'h0000_0001, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001};
            for (int i = 0; i < 5; i++) begin
                step();
                drive(1'b1, 4'(i), sa[i], sb[i], 1'b1);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        end
        #1;
        check("st_count3", 64'(stat_carry_cnt), 64'd3);
        force dut.r_carry_cnt = 16'hFFFF;
        #1;
        release dut.r_carry_cnt;
        drive(1'b1, 4'd7, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        end
        #1;
        check("st_saturate", 64'(stat_carry_cnt), 64'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
